// File: rtl/score4_pkg.sv
// score4_pkg: shared constants and types for the Score 4 (Connect Four) game.
//   NUM_COLS / NUM_ROWS / MAX_MOVES : board geometry and move limit
//   CELL_* : two-bit cell encodings stored in the panel
//   panel_t: board[col][row], row 0 is the bottom row
//   state_t: game sequencer states
package score4_pkg;

  localparam int NUM_COLS  = 7;
  localparam int NUM_ROWS  = 6;
  localparam int MAX_MOVES = 42;

  typedef logic [1:0] cell_t;
  typedef cell_t [NUM_COLS-1:0][NUM_ROWS-1:0] panel_t;
  typedef logic [2:0] col_t;
  typedef logic [2:0] height_t;

  localparam cell_t CELL_EMPTY = 2'b00;
  localparam cell_t CELL_P0    = 2'b01;
  localparam cell_t CELL_P1    = 2'b10;

  typedef enum logic [1:0] {
    S_WAIT_MOVE = 2'd0,
    S_CHECK     = 2'd1,
    S_GAME_OVER = 2'd2
  } state_t;

endpackage

// File: rtl/score4_game_ctrl_find_winner.sv
// find_winner: combinational four-in-a-line detector.
//   panel  : current board
//   turn   : player to move next; the player tested is the one who just
//            moved, i.e. ~turn
//   exists : a horizontal, vertical or diagonal line of four exists for
//            the tested player
//   winner : the tested player (~turn)
module find_winner
  import score4_pkg::*;
(
  input  panel_t panel,
  input  logic   turn,
  output logic   exists,
  output logic   winner
);

  cell_t target;

  assign target = turn ? CELL_P0 : CELL_P1;
  assign winner = ~turn;

  always_comb begin
    exists = 1'b0;
    // horizontal
    for (int c = 0; c < NUM_COLS - 3; c++) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (panel[c][r] == target && panel[c+1][r] == target &&
            panel[c+2][r] == target && panel[c+3][r] == target)
          exists = 1'b1;
      end
    end
    // vertical
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int r = 0; r < NUM_ROWS - 3; r++) begin
        if (panel[c][r] == target && panel[c][r+1] == target &&
            panel[c][r+2] == target && panel[c][r+3] == target)
          exists = 1'b1;
      end
    end
    // rising diagonal
    for (int c = 0; c < NUM_COLS - 3; c++) begin
      for (int r = 0; r < NUM_ROWS - 3; r++) begin
        if (panel[c][r] == target && panel[c+1][r+1] == target &&
            panel[c+2][r+2] == target && panel[c+3][r+3] == target)
          exists = 1'b1;
      end
    end
    // falling diagonal
    for (int c = 0; c < NUM_COLS - 3; c++) begin
      for (int r = 3; r < NUM_ROWS; r++) begin
        if (panel[c][r] == target && panel[c+1][r-1] == target &&
            panel[c+2][r-2] == target && panel[c+3][r-3] == target)
          exists = 1'b1;
      end
    end
  end

endmodule

// File: rtl/score4_game_ctrl.sv
// score4_game_ctrl: sequencer for one Score 4 game on a 7x6 board.
//   clk, rst_n  : clock and asynchronous active-low reset
//   new_game    : synchronous clear of board and state (overrides drops)
//   drop_valid, drop_col, drop_ready : column-drop request handshake
//   move_err    : one-cycle pulse after a handshake with an illegal column
//   panel       : authoritative board register
//   turn        : player to move next
//   move_count  : pieces placed so far (0..42)
//   game_over, winner, draw : registered verdict
module score4_game_ctrl
  import score4_pkg::*;
#(
  parameter logic FIRST_TURN = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       drop_valid,
  input  logic [2:0] drop_col,
  output logic       drop_ready,
  output logic       move_err,
  output panel_t     panel,
  output logic       turn,
  output logic [5:0] move_count,
  output logic       game_over,
  output logic       winner,
  output logic       draw
);

  state_t                      state, state_next;
  height_t [NUM_COLS-1:0]      height;
  height_t                     sel_height;
  logic                        col_ok;
  logic                        accept;
  logic                        reject;
  logic                        win_exists;
  logic                        win_player;

  find_winner u_find_winner (
    .panel  (panel),
    .turn   (turn),
    .exists (win_exists),
    .winner (win_player)
  );

  assign drop_ready = (state == S_WAIT_MOVE);
  assign game_over  = (state == S_GAME_OVER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT_MOVE;
    else        state <= state_next;
  end

  always_comb begin
    // Column 7 matches no entry, so sel_height stays 0 and col_ok rejects it
    sel_height = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (drop_col == col_t'(c)) sel_height = height[c];
    end
    col_ok     = (drop_col < col_t'(NUM_COLS)) &&
                 (sel_height < height_t'(NUM_ROWS));
    accept     = 1'b0;
    reject     = 1'b0;
    state_next = state;
    case (state)
      S_WAIT_MOVE: begin
        if (drop_valid) begin
          if (col_ok) begin
            accept     = 1'b1;
            state_next = S_CHECK;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_CHECK: begin
        // A win on the final piece still reaches S_GAME_OVER as a win
        if (win_exists || move_count == 6'(MAX_MOVES))
          state_next = S_GAME_OVER;
        else
          state_next = S_WAIT_MOVE;
      end
      S_GAME_OVER: state_next = S_GAME_OVER;
      default:     state_next = S_WAIT_MOVE;
    endcase
    if (new_game) begin
      state_next = S_WAIT_MOVE;
      accept     = 1'b0;
      reject     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      panel      <= '0;
      height     <= '0;
      move_count <= '0;
      turn       <= FIRST_TURN;
      winner     <= 1'b0;
      draw       <= 1'b0;
      move_err   <= 1'b0;
    end else begin
      move_err <= reject;
      if (new_game) begin
        panel      <= '0;
        height     <= '0;
        move_count <= '0;
        turn       <= FIRST_TURN;
        winner     <= 1'b0;
        draw       <= 1'b0;
      end else begin
        if (accept) begin
          for (int c = 0; c < NUM_COLS; c++) begin
            if (drop_col == col_t'(c)) begin
              height[c] <= height[c] + height_t'(1);
              for (int r = 0; r < NUM_ROWS; r++) begin
                if (sel_height == height_t'(r))
                  panel[c][r] <= turn ? CELL_P1 : CELL_P0;
              end
            end
          end
          move_count <= move_count + 6'd1;
          turn       <= ~turn;
        end
        if (state == S_CHECK) begin
          if (win_exists) begin
            winner <= win_player;
            draw   <= 1'b0;
          end else if (move_count == 6'(MAX_MOVES)) begin
            draw <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_score4_game_ctrl.sv
module tb_score4_game_ctrl;
  import score4_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_game = 1'b0;
  logic       drop_valid = 1'b0;
  logic [2:0] drop_col = 3'd0;

  logic       drop_ready, move_err, turn, game_over, winner, draw;
  panel_t     panel;
  logic [5:0] move_count;

  logic       drop_ready1, move_err1, turn1, game_over1, winner1, draw1;
  panel_t     panel1;
  logic [5:0] move_count1;

  int n_checks = 0;
  int n_pass   = 0;

  panel_t mpanel;
  int     mh[NUM_COLS];
  logic   mturn;
  int     mcount;

  always #5 clk = ~clk;

  score4_game_ctrl #(.FIRST_TURN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game),
    .drop_valid(drop_valid), .drop_col(drop_col), .drop_ready(drop_ready),
    .move_err(move_err), .panel(panel), .turn(turn), .move_count(move_count),
    .game_over(game_over), .winner(winner), .draw(draw)
  );

  score4_game_ctrl #(.FIRST_TURN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .new_game(new_game),
    .drop_valid(drop_valid), .drop_col(drop_col), .drop_ready(drop_ready1),
    .move_err(move_err1), .panel(panel1), .turn(turn1), .move_count(move_count1),
    .game_over(game_over1), .winner(winner1), .draw(draw1)
  );

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_clear();
    mpanel = '0;
    for (int c = 0; c < NUM_COLS; c++) mh[c] = 0;
    mturn  = 1'b0;
    mcount = 0;
  endtask

  task automatic drop(input int col);
    int n;
    n = 0;
    @(negedge clk);
    while (!drop_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!drop_ready) begin
      chk("ready_timeout", 96'(drop_ready), 96'd1);
    end else begin
      drop_valid = 1'b1;
      drop_col   = 3'(col);
      if (col < NUM_COLS && mh[col] < NUM_ROWS) begin
        mpanel[col][mh[col]] = mturn ? CELL_P1 : CELL_P0;
        mh[col]++;
        mcount++;
        mturn = ~mturn;
      end
      @(negedge clk);
      drop_valid = 1'b0;
    end
  endtask

  task automatic start_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_clear();
  endtask

  initial begin
    model_clear();
    #12;
    // reset state
    chk("rst_panel", 96'(panel), 96'd0);
    chk("rst_count", 96'(move_count), 96'd0);
    chk("rst_turn", 96'(turn), 96'd0);
    chk("rst_turn_ft1", 96'(turn1), 96'd1);
    chk("rst_ready", 96'(drop_ready), 96'd1);
    chk("rst_over", 96'(game_over), 96'd0);
    chk("rst_draw", 96'(draw), 96'd0);
    chk("rst_err", 96'(move_err), 96'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // mid-game asynchronous reset
    for (int i = 0; i < 5; i++) drop(i);
    chk("mid_count", 96'(move_count), 96'd5);
    chk("mid_panel", 96'(panel), 96'(mpanel));
    #2 rst_n = 1'b0;
    #1;
    chk("async_panel", 96'(panel), 96'd0);
    chk("async_count", 96'(move_count), 96'd0);
    chk("async_turn", 96'(turn), 96'd0);
    chk("async_ready", 96'(drop_ready), 96'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();

    // vertical win for player 0
    drop(0); drop(1); drop(0); drop(1); drop(0); drop(1); drop(0);
    chk("vert_not_yet", 96'(game_over), 96'd0);
    @(negedge clk);
    chk("vert_over", 96'(game_over), 96'd1);
    chk("vert_winner", 96'(winner), 96'd0);
    chk("vert_draw", 96'(draw), 96'd0);
    for (int r = 0; r < 4; r++) chk("vert_cell", 96'(panel[0][r]), 96'(CELL_P0));
    chk("vert_panel", 96'(panel), 96'(mpanel));
    drop_valid = 1'b1;
    drop_col   = 3'd2;
    repeat (3) @(negedge clk);
    drop_valid = 1'b0;
    chk("over_ignore_count", 96'(move_count), 96'd7);
    chk("over_ignore_err", 96'(move_err), 96'd0);
    chk("over_ignore_panel", 96'(panel), 96'(mpanel));
    chk("over_ready", 96'(drop_ready), 96'd0);

    // rising-diagonal win by the first mover
    start_new_game();
    chk("ng_panel", 96'(panel), 96'd0);
    chk("ng_over", 96'(game_over), 96'd0);
    drop(0); drop(1); drop(1); drop(2); drop(2); drop(3);
    drop(2); drop(3); drop(3); drop(6); drop(3);
    @(negedge clk);
    chk("diag_over", 96'(game_over), 96'd1);
    chk("diag_winner", 96'(winner), 96'd0);
    chk("diag_draw", 96'(draw), 96'd0);
    chk("diag_count", 96'(move_count), 96'd11);
    chk("diag_panel", 96'(panel), 96'(mpanel));
    chk("diag_over_ft1", 96'(game_over1), 96'd1);
    chk("diag_winner_ft1", 96'(winner1), 96'd1);

    // full column
    start_new_game();
    for (int i = 0; i < 6; i++) drop(4);
    chk("full_count", 96'(move_count), 96'd6);
    chk("full_err_pre", 96'(move_err), 96'd0);
    drop(4);
    chk("full_err", 96'(move_err), 96'd1);
    chk("full_count_hold", 96'(move_count), 96'd6);
    chk("full_turn_hold", 96'(turn), 96'd0);
    chk("full_panel", 96'(panel), 96'(mpanel));
    chk("full_ready", 96'(drop_ready), 96'd1);
    @(negedge clk);
    chk("full_err_pulse", 96'(move_err), 96'd0);

    // illegal column 7
    drop(7);
    chk("col7_err", 96'(move_err), 96'd1);
    chk("col7_panel", 96'(panel), 96'(mpanel));
    chk("col7_count", 96'(move_count), 96'd6);
    @(negedge clk);
    chk("col7_err_pulse", 96'(move_err), 96'd0);

    // draw: column parities A A B B A A A leave no four in a line
    start_new_game();
    for (int i = 0; i < 6; i++) drop(0);
    for (int i = 0; i < 6; i++) drop(1);
    drop(4);
    for (int i = 0; i < 6; i++) drop(2);
    for (int i = 0; i < 6; i++) drop(3);
    for (int i = 0; i < 5; i++) drop(4);
    for (int i = 0; i < 6; i++) drop(5);
    for (int i = 0; i < 5; i++) drop(6);
    chk("draw_pending", 96'(game_over), 96'd0);
    drop(6);
    @(negedge clk);
    chk("draw_over", 96'(game_over), 96'd1);
    chk("draw_flag", 96'(draw), 96'd1);
    chk("draw_count", 96'(move_count), 96'd42);
    chk("draw_panel", 96'(panel), 96'(mpanel));

    // new_game coincident with a drop request
    @(negedge clk);
    new_game   = 1'b1;
    drop_valid = 1'b1;
    drop_col   = 3'd0;
    @(negedge clk);
    new_game   = 1'b0;
    drop_valid = 1'b0;
    chk("ngd_panel", 96'(panel), 96'd0);
    chk("ngd_count", 96'(move_count), 96'd0);
    chk("ngd_over", 96'(game_over), 96'd0);
    chk("ngd_draw", 96'(draw), 96'd0);
    chk("ngd_err", 96'(move_err), 96'd0);
    chk("ngd_ready", 96'(drop_ready), 96'd1);
    @(negedge clk);
    chk("ngd_no_place", 96'(move_count), 96'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
